// File: rtl/pulse_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pulse_seq_pkg : address map, mode/state encodings and reset defaults      |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
package pulse_seq_pkg;

  localparam int ADDR_PERIOD     = 0;
  localparam int ADDR_MODE       = 1;
  localparam int ADDR_ATT        = 2;
  localparam int ADDR_PULSE_BASE = 4;

  typedef enum logic [1:0] {
    MODE_STOP   = 2'd0,
    MODE_CONT   = 2'd1,
    MODE_SINGLE = 2'd2
  } mode_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned DEF_PERIOD = 32'd2000000;

  function automatic int unsigned def_start(input int idx);
    return (idx == 1) ? 32'd2030 : 32'd0;
  endfunction

  function automatic int unsigned def_width(input int idx);
    return (idx < 2) ? 32'd30 : 32'd0;
  endfunction

  // Reset value of the registered last-pulse-end, derived from the defaults above.
  function automatic int unsigned def_last_end(input int num_pulses);
    int unsigned le;
    le = 0;
    for (int i = 0; i < num_pulses; i++) begin
      if (def_width(i) != 0 && def_start(i) + def_width(i) > le) le = def_start(i) + def_width(i);
    end
    return le;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_window.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pulse_window : active while start <= cnt < start+width (width 0 = off)    |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module pulse_window #(
  parameter int CNT_W = 32
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] start,
  input  logic [CNT_W-1:0] width,
  output logic             active
);

  logic [CNT_W:0] w_end_excl;

  assign w_end_excl = {1'b0, start} + {1'b0, width};
  assign active     = (width != '0) && (cnt >= start) && ({1'b0, cnt} < w_end_excl);

endmodule
`default_nettype wire

// File: rtl/pulse_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pulse_sequencer : N-pulse gate/SYNC/attenuator sequencer, double-buffered |
// | Revision        : 1.0                                                     |
// +--------------------------------------------------------------------------+
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int NUM_PULSES = 4,
  parameter int ATT_W      = 8,
  parameter int ATT_DELAY  = 20000,
  parameter int ADDR_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CNT_W-1:0]  cfg_data,
  input  logic              cfg_commit,
  input  logic              trigger,
  output logic              pulse_out,
  output logic              sync_out,
  output logic [ATT_W-1:0]  att_out,
  output logic              period_start,
  output logic              commit_done,
  output logic              running
);

  localparam int ATT_REG_W = 2 * ATT_W + 1;

  logic [CNT_W-1:0]     sh_period_q, sh_period_d, act_period_q, act_period_d;
  mode_e                sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
  logic [ATT_REG_W-1:0] sh_att_q, sh_att_d, act_att_q, act_att_d;
  logic [CNT_W-1:0]     sh_start_q [NUM_PULSES];
  logic [CNT_W-1:0]     sh_start_d [NUM_PULSES];
  logic [CNT_W-1:0]     sh_width_q [NUM_PULSES];
  logic [CNT_W-1:0]     sh_width_d [NUM_PULSES];
  logic [CNT_W-1:0]     act_start_q[NUM_PULSES];
  logic [CNT_W-1:0]     act_start_d[NUM_PULSES];
  logic [CNT_W-1:0]     act_width_q[NUM_PULSES];
  logic [CNT_W-1:0]     act_width_d[NUM_PULSES];

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pending_q, pending_d;
  logic [CNT_W:0]       last_end_q, last_end_d;

  logic                 pulse_out_q, pulse_out_d, sync_out_q, sync_out_d;
  logic [ATT_W-1:0]     att_out_q, att_out_d;
  logic                 period_start_q, period_start_d, commit_done_q, commit_done_d;
  logic                 running_q, running_d;

  logic [NUM_PULSES-1:0] w_win;
  logic [CNT_W-1:0]      w_period_eff;
  logic                  w_run, w_wrap, w_do_commit, w_pump_sel;
  logic [CNT_W:0]        w_le_shadow;
  logic [CNT_W+1:0]      w_att_thresh;

  generate
    for (genvar gi = 0; gi < NUM_PULSES; gi++) begin : g_win
      pulse_window #(.CNT_W(CNT_W)) u_win (
        .cnt    (cnt_q),
        .start  (act_start_q[gi]),
        .width  (act_width_q[gi]),
        .active (w_win[gi])
      );
    end
  endgenerate

  assign w_run        = (state_q == ST_RUN);
  assign w_period_eff = (act_period_q < CNT_W'(2)) ? CNT_W'(2) : act_period_q;
  assign w_wrap       = w_run && (cnt_q == w_period_eff - CNT_W'(1));
  assign w_do_commit  = pending_q && (!w_run || w_wrap);

  // Shadow bank: decoded writes only; unmapped addresses fall through untouched.
  always_comb begin
    sh_period_d = sh_period_q;
    sh_mode_d   = sh_mode_q;
    sh_att_d    = sh_att_q;
    for (int i = 0; i < NUM_PULSES; i++) begin
      sh_start_d[i] = sh_start_q[i];
      sh_width_d[i] = sh_width_q[i];
    end
    if (cfg_wr) begin
      if (cfg_addr == ADDR_W'(ADDR_PERIOD)) sh_period_d = cfg_data;
      if (cfg_addr == ADDR_W'(ADDR_MODE))   sh_mode_d   = mode_e'(cfg_data[1:0]);
      if (cfg_addr == ADDR_W'(ADDR_ATT))    sh_att_d    = cfg_data[ATT_REG_W-1:0];
      for (int i = 0; i < NUM_PULSES; i++) begin
        if (cfg_addr == ADDR_W'(ADDR_PULSE_BASE + 2 * i))     sh_start_d[i] = cfg_data;
        if (cfg_addr == ADDR_W'(ADDR_PULSE_BASE + 2 * i + 1)) sh_width_d[i] = cfg_data;
      end
    end
  end

  // Active bank and last_end move together so they never disagree for a cycle.
  always_comb begin
    w_le_shadow = '0;
    for (int i = 0; i < NUM_PULSES; i++) begin
      if (sh_width_q[i] != '0 && ({1'b0, sh_start_q[i]} + {1'b0, sh_width_q[i]}) > w_le_shadow)
        w_le_shadow = {1'b0, sh_start_q[i]} + {1'b0, sh_width_q[i]};
    end
    act_period_d = w_do_commit ? sh_period_q : act_period_q;
    act_mode_d   = w_do_commit ? sh_mode_q   : act_mode_q;
    act_att_d    = w_do_commit ? sh_att_q    : act_att_q;
    last_end_d   = w_do_commit ? w_le_shadow : last_end_q;
    for (int i = 0; i < NUM_PULSES; i++) begin
      act_start_d[i] = w_do_commit ? sh_start_q[i] : act_start_q[i];
      act_width_d[i] = w_do_commit ? sh_width_q[i] : act_width_q[i];
    end
    pending_d = cfg_commit || (pending_q && !w_do_commit);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (act_mode_q == MODE_CONT || (act_mode_q == MODE_SINGLE && trigger)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (w_wrap) begin
          cnt_d = '0;
          if (act_mode_q != MODE_CONT) state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign w_att_thresh = {1'b0, last_end_q} + (CNT_W+2)'(ATT_DELAY);
  assign w_pump_sel   = act_att_q[2*ATT_W] && (w_win[0] || ({2'b0, cnt_q} >= w_att_thresh));

  always_comb begin
    pulse_out_d    = w_run && (|w_win);
    sync_out_d     = w_run && ({1'b0, cnt_q} < last_end_q);
    att_out_d      = (w_run && w_pump_sel) ? act_att_q[2*ATT_W-1:ATT_W] : act_att_q[ATT_W-1:0];
    period_start_d = w_run && (cnt_q == '0);
    commit_done_d  = w_do_commit;
    running_d      = w_run;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_period_q    <= CNT_W'(DEF_PERIOD);
      act_period_q   <= CNT_W'(DEF_PERIOD);
      sh_mode_q      <= MODE_STOP;
      act_mode_q     <= MODE_STOP;
      sh_att_q       <= '1;
      act_att_q      <= '1;
      for (int i = 0; i < NUM_PULSES; i++) begin
        sh_start_q[i]  <= CNT_W'(def_start(i));
        sh_width_q[i]  <= CNT_W'(def_width(i));
        act_start_q[i] <= CNT_W'(def_start(i));
        act_width_q[i] <= CNT_W'(def_width(i));
      end
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      pending_q      <= 1'b0;
      last_end_q     <= (CNT_W+1)'(def_last_end(NUM_PULSES));
      pulse_out_q    <= 1'b0;
      sync_out_q     <= 1'b0;
      att_out_q      <= '0;
      period_start_q <= 1'b0;
      commit_done_q  <= 1'b0;
      running_q      <= 1'b0;
    end else begin
      sh_period_q    <= sh_period_d;
      act_period_q   <= act_period_d;
      sh_mode_q      <= sh_mode_d;
      act_mode_q     <= act_mode_d;
      sh_att_q       <= sh_att_d;
      act_att_q      <= act_att_d;
      for (int i = 0; i < NUM_PULSES; i++) begin
        sh_start_q[i]  <= sh_start_d[i];
        sh_width_q[i]  <= sh_width_d[i];
        act_start_q[i] <= act_start_d[i];
        act_width_q[i] <= act_width_d[i];
      end
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      last_end_q     <= last_end_d;
      pulse_out_q    <= pulse_out_d;
      sync_out_q     <= sync_out_d;
      att_out_q      <= att_out_d;
      period_start_q <= period_start_d;
      commit_done_q  <= commit_done_d;
      running_q      <= running_d;
    end
  end

  assign pulse_out    = pulse_out_q;
  assign sync_out     = sync_out_q;
  assign att_out      = att_out_q;
  assign period_start = period_start_q;
  assign commit_done  = commit_done_q;
  assign running      = running_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pulse_sequencer : directed scenarios plus random traffic vs a model    |
// | Revision           : 1.0                                                  |
// +--------------------------------------------------------------------------+
module tb_pulse_sequencer;

  localparam int CNT_W = 32, NP = 4, ATT_W = 8, ATT_DELAY = 10, ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1, cfg_wr = 1'b0, cfg_commit = 1'b0, trigger = 1'b0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [CNT_W-1:0]  cfg_data = '0;
  logic              pulse_out, sync_out, period_start, commit_done, running;
  logic [ATT_W-1:0]  att_out;

  int n_cmp = 0, n_err = 0;
  int c_pulse, c_sync, c_ps, c_run, c_cd, c_att3c;

  // Reference model: configuration as plain integers, timeline as (running, position).
  longint            m_sh_per, m_act_per, m_pos;
  longint            m_sh_start[NP], m_sh_width[NP], m_act_start[NP], m_act_width[NP];
  int                m_sh_mode, m_act_mode;
  logic [2*ATT_W:0]  m_sh_att, m_act_att;
  bit                m_run, m_pend;
  logic              e_pulse, e_sync, e_ps, e_cd, e_run;
  logic [ATT_W-1:0]  e_att;

  pulse_sequencer #(
    .CNT_W(CNT_W), .NUM_PULSES(NP), .ATT_W(ATT_W), .ATT_DELAY(ATT_DELAY), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .trigger(trigger), .pulse_out(pulse_out), .sync_out(sync_out),
    .att_out(att_out), .period_start(period_start), .commit_done(commit_done), .running(running)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_sh_per = 2000000; m_act_per = 2000000;
    m_sh_mode = 0; m_act_mode = 0;
    m_sh_att = '1; m_act_att = '1;
    for (int i = 0; i < NP; i++) begin
      m_sh_start[i] = (i == 1) ? 2030 : 0;
      m_sh_width[i] = (i < 2) ? 30 : 0;
      m_act_start[i] = m_sh_start[i];
      m_act_width[i] = m_sh_width[i];
    end
    m_run = 0; m_pos = 0; m_pend = 0;
  endtask

  task automatic model_step();
    longint per, le;
    bit     any_win, win0, commit_now;
    if (rst) begin
      model_reset();
      e_pulse = 0; e_sync = 0; e_ps = 0; e_cd = 0; e_run = 0; e_att = '0;
      return;
    end
    per = (m_act_per < 2) ? 2 : m_act_per;
    le = 0; any_win = 0; win0 = 0;
    for (int i = 0; i < NP; i++) begin
      if (m_act_width[i] != 0) begin
        if (m_act_start[i] + m_act_width[i] > le) le = m_act_start[i] + m_act_width[i];
        if (m_pos >= m_act_start[i] && m_pos < m_act_start[i] + m_act_width[i]) begin
          any_win = 1;
          if (i == 0) win0 = 1;
        end
      end
    end
    e_run   = m_run;
    e_pulse = m_run && any_win;
    e_sync  = m_run && (m_pos < le);
    e_ps    = m_run && (m_pos == 0);
    e_att   = (m_run && m_act_att[2*ATT_W] && (win0 || m_pos >= le + ATT_DELAY))
              ? m_act_att[2*ATT_W-1:ATT_W] : m_act_att[ATT_W-1:0];
    commit_now = m_pend && (!m_run || m_pos == per - 1);
    e_cd = commit_now;
    if (m_run) begin
      if (m_pos == per - 1) begin
        m_pos = 0;
        if (m_act_mode != 1) m_run = 0;
      end else begin
        m_pos++;
      end
    end else if (m_act_mode == 1 || (m_act_mode == 2 && trigger)) begin
      m_run = 1;
    end
    if (commit_now) begin
      m_act_per = m_sh_per; m_act_mode = m_sh_mode; m_act_att = m_sh_att;
      m_act_start = m_sh_start; m_act_width = m_sh_width;
    end
    m_pend = cfg_commit || (m_pend && !commit_now);
    if (cfg_wr) begin
      int a;
      a = int'(cfg_addr);
      if (a == 0) m_sh_per = longint'(cfg_data);
      else if (a == 1) m_sh_mode = int'(cfg_data[1:0]);
      else if (a == 2) m_sh_att = cfg_data[2*ATT_W:0];
      else if (a >= 4 && a < 4 + 2 * NP) begin
        if (a % 2 == 0) m_sh_start[(a - 4) / 2] = longint'(cfg_data);
        else            m_sh_width[(a - 4) / 2] = longint'(cfg_data);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    c_pulse = 0; c_sync = 0; c_ps = 0; c_run = 0; c_cd = 0; c_att3c = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("pulse_out", {31'b0, pulse_out}, {31'b0, e_pulse});
    chk("sync_out", {31'b0, sync_out}, {31'b0, e_sync});
    chk("att_out", {24'b0, att_out}, {24'b0, e_att});
    chk("period_start", {31'b0, period_start}, {31'b0, e_ps});
    chk("commit_done", {31'b0, commit_done}, {31'b0, e_cd});
    chk("running", {31'b0, running}, {31'b0, e_run});
    c_pulse += int'(pulse_out === 1'b1);
    c_sync  += int'(sync_out === 1'b1);
    c_ps    += int'(period_start === 1'b1);
    c_run   += int'(running === 1'b1);
    c_cd    += int'(commit_done === 1'b1);
    c_att3c += int'(att_out === 8'h3C);
    @(negedge clk);
    cfg_wr = 0; cfg_commit = 0; trigger = 0;
  endtask

  task automatic wr(input int a, input longint d, input bit commit);
    cfg_wr = 1; cfg_addr = ADDR_W'(a); cfg_data = CNT_W'(d); cfg_commit = commit;
    tick();
  endtask

  task automatic wait_pos(input longint p);
    int k;
    k = 0;
    while (!(m_run && m_pos == p) && k < 5000) begin tick(); k++; end
    chk("wait_pos_timeout", k, (k < 5000) ? k : 0);
  endtask

  task automatic wait_cd();
    int k;
    k = 0;
    while (commit_done !== 1'b1 && k < 1000) begin tick(); k++; end
    chk("wait_commit_done", {31'b0, commit_done}, 32'd1);
  endtask

  task automatic wait_ps();
    int k;
    k = 0;
    while (period_start !== 1'b1 && k < 1000) begin tick(); k++; end
    chk("wait_period_start", {31'b0, period_start}, 32'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (running !== 1'b0 && k < 1000) begin tick(); k++; end
    chk("wait_idle", {31'b0, running}, 32'd0);
  endtask

  initial begin
    model_reset();
    rst = 1; tick(); tick();
    chk("reset_att", {24'b0, att_out}, 32'd0);
    chk("reset_running", {31'b0, running}, 32'd0);
    rst = 0; tick();
    chk("idle_att_probe", {24'b0, att_out}, 32'hFF);

    // Defaults with period 100: window 1 (2030..) never fits.
    wr(0, 100, 0); wr(1, 1, 1);
    wait_ps();
    clear_counts(); repeat (200) tick();
    chk("t1_pulse_count", c_pulse, 60);
    chk("t1_period_starts", c_ps, 2);
    chk("t1_sync_count", c_sync, 200);

    // Mid-period commit applies from the next period.
    wait_pos(50); wr(6, 40, 0); wr(7, 10, 1);
    wait_cd();
    clear_counts(); repeat (100) tick();
    chk("t2_pulse_count", c_pulse, 40);
    chk("t2_sync_count", c_sync, 50);

    // Attenuator: pump 0, probe 3C, last_end 60.
    wr(2, 32'h1003C, 0); wr(6, 30, 0); wr(7, 30, 1);
    wait_cd();
    clear_counts(); repeat (100) tick();
    chk("t4_att_probe_count", c_att3c, 40);
    chk("t4_pulse_count", c_pulse, 60);

    // Overlapping windows, then window 1 disabled.
    wr(6, 20, 1); wait_cd();
    clear_counts(); repeat (100) tick();
    chk("t5_overlap_pulse", c_pulse, 50);
    wr(7, 0, 1); wait_cd();
    clear_counts(); repeat (100) tick();
    chk("t5_width0_pulse", c_pulse, 30);
    chk("t5_width0_sync", c_sync, 30);

    // Single shot: one period per trigger, retrigger in RUN ignored.
    wr(1, 2, 1);
    wait_idle();
    repeat (3) tick();
    clear_counts();
    trigger = 1; tick();
    repeat (30) tick();
    trigger = 1; tick();
    repeat (268) tick();
    chk("t3_running_cycles", c_run, 100);
    chk("t3_period_starts", c_ps, 1);
    chk("t3_pulse_count", c_pulse, 30);

    // Reset mid-run with a pending commit.
    wr(1, 1, 1);
    wait_pos(55); wr(0, 50, 1); tick();
    rst = 1; tick();
    chk("t6_rst_running", {31'b0, running}, 32'd0);
    chk("t6_rst_att", {24'b0, att_out}, 32'd0);
    chk("t6_rst_pulse", {31'b0, pulse_out}, 32'd0);
    rst = 0;
    clear_counts(); repeat (20) tick();
    chk("t6_no_commit_done", c_cd, 0);
    chk("t6_stays_idle", c_run, 0);

    // Random traffic against the model.
    rst = 1; tick(); rst = 0;
    wr(0, 40, 0); wr(1, 1, 1);
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        int a;
        a = int'($urandom_range(0, 31));
        cfg_wr   = 1;
        cfg_addr = ADDR_W'(a);
        cfg_data = (a == 0) ? $urandom_range(0, 60) :
                   (a == 1) ? $urandom_range(0, 3)  :
                   (a == 2) ? $urandom : $urandom_range(0, 70);
      end
      cfg_commit = ($urandom_range(0, 15) == 0);
      trigger    = ($urandom_range(0, 7) == 0);
      rst        = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
